exe_muldiv: RTL
===============

Name: exe_muldiv

Overview:
- Multi-cycle RV32M execute unit sitting beside the combinational execute stage.
- Handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Holds the pipeline through pipe_ctrl via stall_out while it works.
- Emits a single-cycle register write toward exe_mem.
- Generalises the R-type path with parametrised width, multiplier latency and a divide early-out.

Parameters:
- XLEN, 32, datapath width (op1, op2, result).
- RADDR_WIDTH, 5, register address width.
- MUL_LATENCY, 2, multiply cycles in state MUL; legal range 1..4.
- DIV_EARLY_OUT, 1, when 1, divide-by-zero and signed overflow finish in one cycle.

Ports:
- clk_in  input  1  clock
- reset_in  input  1  synchronous active-high reset
- valid_in  input  1  an instruction is presented by exe_id
- inst_in  input  32  instruction word
- op1_in  input  XLEN  rs1 value
- op2_in  input  XLEN  rs2 value
- reg_waddr_in  input  RADDR_WIDTH  rd
- flush_in  input  1  pipe_ctrl kill (taken jump or branch)
- reg_wdata_out  output  XLEN  result toward exe_mem
- reg_waddr_out  output  RADDR_WIDTH  rd toward exe_mem
- reg_we_out  output  1  one-cycle write strobe
- stall_out  output  1  hold request to pipe_ctrl
- busy_out  output  1  FSM not in IDLE

Behaviour:
- Interface: one clock, clk_in; reset_in is synchronous and active-high.
- Reset values: state=IDLE, reg_wdata_out=0, reg_waddr_out=0, reg_we_out=0, busy_out=0. stall_out is 0 while reset_in=1.
- Accept condition: IDLE & valid_in & opcode==INST_TYPE_R & funct7==7'b0000001 & !flush_in.
- On accept, latch op1, op2, funct3 and rd. No latched value changes until the unit returns to IDLE.
- States: IDLE, MUL, DIV, DONE.
- IDLE -> MUL when funct3[2]=0.
- IDLE -> DIV when funct3[2]=1.
- MUL -> DONE after MUL_LATENCY cycles.
- DIV -> DONE after XLEN iterations. With DIV_EARLY_OUT=1, a zero divisor or signed overflow goes to DONE after 1 cycle.
- DONE -> IDLE unconditionally.
- stall_out is combinational: high in the accept cycle and in every MUL or DIV cycle; low in DONE and in idle non-accept cycles.
- reg_we_out=1 for exactly the DONE cycle, gated by rd!=0. reg_wdata_out and reg_waddr_out are valid in that cycle and hold their values afterwards.
- Latency, accept to write strobe:
  - multiply: MUL_LATENCY+1 cycles
  - divide: XLEN+1 cycles
  - early-out divide: 2 cycles
- Multiply: full 2*XLEN product with sign-extension per variant.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
  - Operand signedness: MULH signed x signed; MULHSU signed op1 x unsigned op2; MULHU unsigned x unsigned.
- Divide: restoring, on magnitudes; sign fixed at DONE.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divisor zero: quotient = all ones; remainder = dividend.
- Signed overflow (dividend = -2^(XLEN-1), divisor = -1): quotient = dividend; remainder = 0.
- flush_in=1 in any state: next state IDLE, reg_we_out=0 on the next edge, no write for the killed op. flush_in has priority over DONE.
- valid_in while not IDLE is ignored; pipe_ctrl holds exe_id through stall_out.
- An M-op presented in the DONE cycle is not accepted; it is accepted the following IDLE cycle.
- Non-M instructions never assert stall_out, busy_out or reg_we_out.
- reset_in mid-operation behaves like flush_in and also clears all outputs.

Decomposition:
- defines.v additions:
  - FUNCT7_M
  - funct3 codes: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  - 2-bit MD_IDLE, MD_MUL, MD_DIV, MD_DONE state encodings
  - existing INST_TYPE_R, ZERO, ZERO_REG, WRITE_ENABLE and WRITE_DISABLE reused
- Sub-module exe_div_iter:
  - one restoring shift-subtract step per cycle
  - ports: start, magnitudes, quotient, remainder, done
- Multiplier: kept inline as a MUL_LATENCY-deep register pipeline.

Test Plan:
1. MUL, op1=0xFFFFFFFE, op2=3, rd=5, MUL_LATENCY=2 -> stall_out high 3 cycles, then reg_we_out=1, waddr=5, wdata=0xFFFFFFFA.
2. MULHSU, op1=0xFFFFFFFF, op2=0xFFFFFFFF -> wdata=0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE.
3. DIV, op1=0xFFFFFFF9 (-7), op2=2 -> write strobe on cycle 33 after accept, wdata=0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF.
4. DIVU by 0, op1=0x1234 -> wdata=0xFFFFFFFF on cycle 2. REMU by 0 -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
5. flush_in pulsed on cycle 10 of a DIV -> busy_out=0 the next cycle and no reg_we_out ever. A new MUL accepted the following cycle completes correctly.
6. MUL with rd=0 -> full stall sequence, reg_we_out stays 0. ADD (funct7=0) with valid_in -> stall_out=0 and busy_out=0 throughout.

Source files
------------

// File: rtl/exe_muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide execute unit.
// Opcode/funct fields, funct3 operation codes and the unit's FSM state type.
package exe_muldiv_pkg;

  localparam logic [6:0] INST_TYPE_R = 7'b0110011;
  localparam logic [6:0] FUNCT7_M    = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [4:0] ZERO_REG      = 5'd0;
  localparam logic       WRITE_ENABLE  = 1'b1;
  localparam logic       WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  function automatic logic is_m_op(input logic [31:0] inst);
    return (inst[6:0] == INST_TYPE_R) && (inst[31:25] == FUNCT7_M);
  endfunction

endpackage

// File: rtl/exe_div_iter.sv
// Restoring unsigned divider: one shift-subtract step per clock on magnitudes.
// The first step is folded into the start cycle so the result is ready XLEN-1 cycles later.
module exe_div_iter
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_srst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder,
  output logic            o_done
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dsr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  logic [XLEN-1:0]  w_src_quo;
  logic [XLEN-1:0]  w_src_rem;
  logic [XLEN-1:0]  w_dsr;
  logic [XLEN:0]    w_trial;
  logic [XLEN-1:0]  w_nxt_quo;
  logic [XLEN-1:0]  w_nxt_rem;

  always_comb begin
    w_src_quo = i_start ? i_dividend : r_quo;
    w_src_rem = i_start ? '0 : r_rem;
    w_dsr     = i_start ? i_divisor : r_dsr;
    w_trial   = {w_src_rem, w_src_quo[XLEN-1]} - {1'b0, w_dsr};
    // A non-negative trial difference means the divisor fits: keep it, quotient bit 1.
    if (!w_trial[XLEN]) begin
      w_nxt_rem = w_trial[XLEN-1:0];
      w_nxt_quo = {w_src_quo[XLEN-2:0], 1'b1};
    end else begin
      w_nxt_rem = {w_src_rem[XLEN-2:0], w_src_quo[XLEN-1]};
      w_nxt_quo = {w_src_quo[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dsr <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_quo <= w_nxt_quo;
      r_rem <= w_nxt_rem;
      r_dsr <= i_divisor;
      r_cnt <= CNT_W'(XLEN - 1);
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        r_quo <= w_nxt_quo;
        r_rem <= w_nxt_rem;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
  assign o_done      = r_run && (r_cnt == '0);

endmodule

// File: rtl/exe_muldiv.sv
// Multi-cycle RV32M execute unit: stalls the pipe while a MUL*/DIV*/REM* op runs,
// then issues a single-cycle register write toward exe_mem.
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int RADDR_WIDTH   = 5,
  parameter int MUL_LATENCY   = 2,
  parameter int DIV_EARLY_OUT = 1
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   valid_in,
  input  logic [31:0]            inst_in,
  input  logic [XLEN-1:0]        op1_in,
  input  logic [XLEN-1:0]        op2_in,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_in,
  input  logic                   flush_in,
  output logic [XLEN-1:0]        reg_wdata_out,
  output logic [RADDR_WIDTH-1:0] reg_waddr_out,
  output logic                   reg_we_out,
  output logic                   stall_out,
  output logic                   busy_out
);

  localparam int PW = 2 * XLEN;

  md_state_e              r_state;
  md_state_e              w_state_next;
  logic [XLEN-1:0]        r_op1;
  logic [XLEN-1:0]        r_op2;
  logic [2:0]             r_funct3;
  logic [RADDR_WIDTH-1:0] r_rd;
  logic [2:0]             r_mul_cnt;
  logic [XLEN-1:0]        r_wdata;
  logic [RADDR_WIDTH-1:0] r_waddr;
  logic                   r_we;

  logic w_accept;
  logic w_finish;
  logic w_div_start;

  assign w_accept = (r_state == MD_IDLE) && valid_in && is_m_op(inst_in) && !flush_in;

  // Divider magnitudes come straight from the inputs so it can start on the accept edge.
  logic            w_in_signed;
  logic [XLEN-1:0] w_dvd_mag;
  logic [XLEN-1:0] w_dsr_mag;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic            w_div_done;

  assign w_in_signed = ~inst_in[12];
  assign w_dvd_mag   = (w_in_signed && op1_in[XLEN-1]) ? (~op1_in + 1'b1) : op1_in;
  assign w_dsr_mag   = (w_in_signed && op2_in[XLEN-1]) ? (~op2_in + 1'b1) : op2_in;
  assign w_div_start = w_accept && inst_in[14];

  exe_div_iter #(
    .XLEN (XLEN)
  ) u_div (
    .i_clk       (clk_in),
    .i_srst      (reset_in),
    .i_start     (w_div_start),
    .i_dividend  (w_dvd_mag),
    .i_divisor   (w_dsr_mag),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_done      (w_div_done)
  );

  // Multiply on latched operands; sign-extend to the full product width per variant.
  logic                  w_a_sgn;
  logic                  w_b_sgn;
  logic signed [PW+1:0]  w_mul_a;
  logic signed [PW+1:0]  w_mul_b;
  logic signed [PW+1:0]  w_mul_full;
  logic [PW-1:0]         w_prod;
  logic [PW-1:0]         w_mul_res;

  assign w_a_sgn    = (r_funct3 == F3_MULH) || (r_funct3 == F3_MULHSU);
  assign w_b_sgn    = (r_funct3 == F3_MULH);
  assign w_mul_a    = {{(XLEN+2){w_a_sgn & r_op1[XLEN-1]}}, r_op1};
  assign w_mul_b    = {{(XLEN+2){w_b_sgn & r_op2[XLEN-1]}}, r_op2};
  assign w_mul_full = w_mul_a * w_mul_b;
  assign w_prod     = w_mul_full[PW-1:0];

  generate
    if (MUL_LATENCY > 1) begin : g_mul_pipe
      localparam int DEPTH = MUL_LATENCY - 1;
      logic [PW-1:0] r_mul_pipe [DEPTH];
      always_ff @(posedge clk_in) begin
        r_mul_pipe[0] <= w_prod;
        for (int i = 1; i < DEPTH; i++) begin
          r_mul_pipe[i] <= r_mul_pipe[i-1];
        end
      end
      assign w_mul_res = r_mul_pipe[DEPTH-1];
    end else begin : g_mul_comb
      assign w_mul_res = w_prod;
    end
  endgenerate

  // Divide sign fix-up and the two architecturally defined corner cases.
  logic            w_div_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic [XLEN-1:0] w_div_res;
  logic [XLEN-1:0] w_result;

  assign w_div_signed = ~r_funct3[0];
  assign w_neg_a      = w_div_signed && r_op1[XLEN-1];
  assign w_neg_b      = w_div_signed && r_op2[XLEN-1];
  assign w_div_zero   = (r_op2 == '0);
  assign w_div_ovf    = w_div_signed && (r_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (r_op2 == '1);

  always_comb begin
    w_div_res = '0;
    if (r_funct3[1]) begin
      if (w_div_zero)     w_div_res = r_op1;
      else if (w_div_ovf) w_div_res = '0;
      else                w_div_res = w_neg_a ? (~w_rem + 1'b1) : w_rem;
    end else begin
      if (w_div_zero)     w_div_res = '1;
      else if (w_div_ovf) w_div_res = r_op1;
      else                w_div_res = (w_neg_a ^ w_neg_b) ? (~w_quo + 1'b1) : w_quo;
    end

    w_result = '0;
    if (r_funct3[2])               w_result = w_div_res;
    else if (r_funct3 == F3_MUL)   w_result = w_mul_res[XLEN-1:0];
    else                           w_result = w_mul_res[PW-1:XLEN];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MD_IDLE: if (w_accept) w_state_next = inst_in[14] ? MD_DIV : MD_MUL;
      MD_MUL:  if (r_mul_cnt == 3'(MUL_LATENCY - 1)) w_state_next = MD_DONE;
      MD_DIV:  if (((DIV_EARLY_OUT != 0) && (w_div_zero || w_div_ovf)) || w_div_done)
                 w_state_next = MD_DONE;
      MD_DONE: w_state_next = MD_IDLE;
      default: w_state_next = MD_IDLE;
    endcase
    if (flush_in) w_state_next = MD_IDLE;
  end

  // Result registers load on the edge into DONE so they are valid during DONE.
  assign w_finish = (r_state != MD_DONE) && (w_state_next == MD_DONE);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state   <= MD_IDLE;
      r_op1     <= '0;
      r_op2     <= '0;
      r_funct3  <= '0;
      r_rd      <= '0;
      r_mul_cnt <= '0;
      r_wdata   <= '0;
      r_waddr   <= '0;
      r_we      <= WRITE_DISABLE;
    end else begin
      r_state <= w_state_next;
      r_we    <= WRITE_DISABLE;
      if (w_accept) begin
        r_op1     <= op1_in;
        r_op2     <= op2_in;
        r_funct3  <= inst_in[14:12];
        r_rd      <= reg_waddr_in;
        r_mul_cnt <= '0;
      end else if (r_state == MD_MUL) begin
        r_mul_cnt <= r_mul_cnt + 1'b1;
      end
      if (w_finish) begin
        r_wdata <= w_result;
        r_waddr <= r_rd;
        r_we    <= (r_rd != RADDR_WIDTH'(ZERO_REG)) ? WRITE_ENABLE : WRITE_DISABLE;
      end
    end
  end

  assign reg_wdata_out = r_wdata;
  assign reg_waddr_out = r_waddr;
  assign reg_we_out    = r_we;
  assign busy_out      = (r_state != MD_IDLE);
  assign stall_out     = !reset_in && (w_accept || (r_state == MD_MUL) || (r_state == MD_DIV));

  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, inst_in[24:15], inst_in[11:7], w_mul_full[PW+1:PW]};

endmodule
